// File: rtl/ca_pkg.sv
// Shared types and default constants for the CA sequence checker.
// Imported by the checker top and the rule sub-module.
package ca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_TRACK = 2'd2
  } ca_state_e;

  localparam int         CA_ARRAY_WIDTH   = 11;
  localparam logic [7:0] CA_RULE          = 8'd30;
  localparam int         CA_LOCK_MATCHES  = 4;
  localparam int         CA_RESYNC_MISSES = 3;
  localparam int         CA_CNT_WIDTH     = 16;

endpackage

// File: rtl/ca_next_gen.sv
// One elementary-CA generation step, 3-cell neighbourhood, circular wrap.
// Pure combinational; shared with the generator side.
module ca_next_gen
  import ca_pkg::*;
#(
  parameter int         ARRAY_WIDTH = CA_ARRAY_WIDTH,
  parameter logic [7:0] RULE        = CA_RULE
) (
  input  logic [ARRAY_WIDTH-1:0] i_gen,
  output logic [ARRAY_WIDTH-1:0] o_gen
);

  for (genvar i = 0; i < ARRAY_WIDTH; i++) begin : g_cell
    localparam int L = (i + 1) % ARRAY_WIDTH;
    localparam int R = (i + ARRAY_WIDTH - 1) % ARRAY_WIDTH;
    assign o_gen[i] = RULE[{i_gen[L], i_gen[i], i_gen[R]}];
  end

endmodule

// File: rtl/ca_seq_checker.sv
// Tracks a received CA sequence: seeds, locks after a match run,
// flywheels through isolated errors and re-seeds after a miss run.
module ca_seq_checker
  import ca_pkg::*;
#(
  parameter int         ARRAY_WIDTH   = CA_ARRAY_WIDTH,
  parameter logic [7:0] RULE          = CA_RULE,
  parameter int         LOCK_MATCHES  = CA_LOCK_MATCHES,
  parameter int         RESYNC_MISSES = CA_RESYNC_MISSES,
  parameter int         CNT_WIDTH     = CA_CNT_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_valid,
  input  logic [ARRAY_WIDTH-1:0] i_word,
  output logic                   o_locked,
  output logic                   o_err,
  output logic [CNT_WIDTH-1:0]   o_err_cnt,
  output logic [CNT_WIDTH-1:0]   o_word_cnt
);

  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int XW = $clog2(RESYNC_MISSES + 1);
  localparam logic [MW-1:0] MLIM = MW'(LOCK_MATCHES);
  localparam logic [XW-1:0] XLIM = XW'(RESYNC_MISSES);

  ca_state_e state_q, state_d;

  logic [ARRAY_WIDTH-1:0] ref_q, ref_d, pred;
  logic [MW-1:0]          mrun_q, mrun_d, mrun_inc;
  logic [XW-1:0]          xrun_q, xrun_d, xrun_inc;
  logic                   lock_q, lock_d;
  logic                   err_q, err_d;
  logic [CNT_WIDTH-1:0]   ecnt_q, ecnt_d;
  logic [CNT_WIDTH-1:0]   wcnt_q, wcnt_d;
  logic                   hit;
  logic                   trk;

  ca_next_gen #(
    .ARRAY_WIDTH (ARRAY_WIDTH),
    .RULE        (RULE)
  ) u_next (
    .i_gen (ref_q),
    .o_gen (pred)
  );

  assign hit      = (i_word == pred);
  assign trk      = i_valid && (state_q == ST_TRACK);
  assign mrun_inc = (mrun_q == MLIM) ? mrun_q : mrun_q + 1'b1;
  assign xrun_inc = (xrun_q == XLIM) ? xrun_q : xrun_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_start) begin
      state_d = ST_SEED;
    end else if (i_valid) begin
      unique case (state_q)
        ST_SEED:  state_d = ST_TRACK;
        ST_TRACK: begin
          if (!hit && lock_q && xrun_inc == XLIM)
            state_d = ST_SEED;
        end
        default: ;
      endcase
    end
  end

  // start outranks a same-cycle valid word, which is dropped
  always_comb begin
    ref_d  = ref_q;
    mrun_d = mrun_q;
    xrun_d = xrun_q;
    lock_d = lock_q;
    err_d  = 1'b0;
    ecnt_d = ecnt_q;
    wcnt_d = wcnt_q;
    if (i_start) begin
      mrun_d = '0;
      xrun_d = '0;
      lock_d = 1'b0;
      ecnt_d = '0;
      wcnt_d = '0;
    end else if (i_valid && state_q == ST_SEED) begin
      ref_d  = i_word;
      mrun_d = '0;
      xrun_d = '0;
    end else if (trk) begin
      if (!(&wcnt_q)) wcnt_d = wcnt_q + 1'b1;
      if (hit) begin
        ref_d  = i_word;
        mrun_d = mrun_inc;
        xrun_d = '0;
        if (mrun_inc == MLIM) lock_d = 1'b1;
      end else if (!lock_q) begin
        ref_d  = i_word;
        mrun_d = '0;
      end else begin
        ref_d  = pred;
        err_d  = 1'b1;
        xrun_d = xrun_inc;
        if (!(&ecnt_q)) ecnt_d = ecnt_q + 1'b1;
        if (xrun_inc == XLIM) lock_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ref_q  <= '0;
      mrun_q <= '0;
      xrun_q <= '0;
      lock_q <= 1'b0;
      err_q  <= 1'b0;
      ecnt_q <= '0;
      wcnt_q <= '0;
    end else begin
      ref_q  <= ref_d;
      mrun_q <= mrun_d;
      xrun_q <= xrun_d;
      lock_q <= lock_d;
      err_q  <= err_d;
      ecnt_q <= ecnt_d;
      wcnt_q <= wcnt_d;
    end
  end

  always_comb begin
    o_locked   = lock_q;
    o_err      = err_q;
    o_err_cnt  = ecnt_q;
    o_word_cnt = wcnt_q;
  end

endmodule

// File: doc/ca_seq_checker.md
CA_SEQ_CHECKER -- requirements
Module: ca_seq_checker

Interface
REQ-001 SHALL have parameter ARRAY_WIDTH, default 11: width of the checked CA word.
REQ-002 SHALL have parameter RULE, default 30: 8-bit elementary rule table; neighbourhood is fixed at 3 cells.
REQ-003 SHALL have parameter LOCK_MATCHES, default 4: consecutive predicted matches needed to declare lock.
REQ-004 SHALL have parameter RESYNC_MISSES, default 3: consecutive mismatches while locked that force re-seed.
REQ-005 SHALL have parameter CNT_WIDTH, default 16: width of the word and error counters.
REQ-006 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port i_start, input, 1: one-cycle request that clears the counters and starts seeding.
REQ-009 SHALL have port i_valid, input, 1: i_word is sampled this cycle.
REQ-010 SHALL have port i_word, input, ARRAY_WIDTH: received CA generation word.
REQ-011 SHALL have port o_locked, output, 1: checker is tracking the sequence.
REQ-012 SHALL have port o_err, output, 1: one-cycle pulse for each mismatch counted.
REQ-013 SHALL have port o_err_cnt, output, CNT_WIDTH: saturating count of mismatches.
REQ-014 SHALL have port o_word_cnt, output, CNT_WIDTH: saturating count of words accepted in TRACK.

Function
REQ-015 SHALL compute the predicted word as follows: bit i = RULE[{ref[(i+1) mod W], ref[i], ref[(i-1) mod W]}], with circular wrap at both ends.
REQ-016 SHALL implement the state machine IDLE -> SEED -> TRACK.
REQ-017 SHALL leave IDLE only on i_start; i_valid in IDLE is ignored.
REQ-018 SHALL, in SEED on i_valid, load ref <= i_word, clear the match and miss runs, and move to TRACK the next cycle; the seed word is not counted in o_word_cnt.
REQ-019 SHALL, in TRACK on i_valid, compare i_word against predict(ref) and increment o_word_cnt (saturating).
REQ-020 SHALL, on a match, set ref <= i_word, increment the match run (saturating), clear the miss run, and register o_locked=1 once the match run reaches LOCK_MATCHES.
REQ-021 SHALL, on a mismatch while unlocked, set ref <= i_word (in-place re-seed) and clear the match run, with no o_err pulse and no error-count increment.
REQ-022 SHALL, on a mismatch while locked, set ref <= predict(ref) (flywheel), pulse o_err on the next cycle, increment o_err_cnt (saturating at all-ones), and increment the miss run.
REQ-023 SHALL, when the miss run reaches RESYNC_MISSES, clear o_locked and move to SEED; o_err_cnt is retained.
REQ-024 SHALL, on i_start in SEED or TRACK, clear o_err_cnt, o_word_cnt and o_locked, and go to SEED; i_start wins over a simultaneous i_valid, whose word is discarded.
REQ-025 SHALL produce registered outputs with one-cycle latency from the sampled i_valid.
REQ-026 SHALL hold all state in cycles where i_valid=0.

Reset
REQ-027 SHALL, on i_rst=1 at a clock edge, set the state to IDLE; ref, both runs and both counters to 0; and o_locked=0, o_err=0.
REQ-028 SHALL give i_rst priority over i_start and i_valid, including mid-TRACK.

Structure
REQ-029 SHALL take the state typedef (IDLE/SEED/TRACK) and the default parameter constants from shared package ca_pkg.
REQ-030 SHALL implement the rule function in one combinational sub-module, ca_next_gen (params ARRAY_WIDTH, RULE; ports i_gen, o_gen), reusable by the generator side.

Verification
REQ-031 SHALL cover reset: assert i_rst mid-TRACK while locked -> next cycle IDLE, all outputs 0.
REQ-032 SHALL cover lock: W=11, RULE=30, start, then feed 0x020, 0x070, 0x0C8 and 2 further correct generations -> o_locked=1 after the 4th match, o_err_cnt=0, o_word_cnt=4.
REQ-033 SHALL cover a single error while locked: inject 0x000 in place of one word -> one o_err pulse, o_err_cnt=1, the following correct word matches through the flywheel, o_locked stays 1.
REQ-034 SHALL cover resync: 3 consecutive bad words while locked -> o_err_cnt=3, o_locked=0, state SEED, and 4 correct words after a new seed relock.
REQ-035 SHALL cover saturation: CNT_WIDTH=4 with 20 locked mismatches (resync disabled by RESYNC_MISSES=31) -> o_err_cnt=0xF and held.
REQ-036 SHALL cover simultaneous events: i_start and i_valid in the same cycle in TRACK -> counters 0, word discarded, next valid word becomes the seed.
